// File: rtl/cfg_pkg.sv
// Build-time sizing for the stack pool: number of contexts and shared entries.
package cfg_pkg;
  localparam int unsigned STK_CTX_N = 4;
  localparam int unsigned STK_PTR_N = 16;
endpackage

// File: rtl/std_pkg.sv
// Shared pointer type for entries of the stack pool.
package std_pkg;
  localparam int unsigned PTR_W = $clog2(cfg_pkg::STK_PTR_N);
  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/stk_pkg.sv
// Command, error, context and FSM types for the linked-list stack pipeline.
package stk_pkg;
  localparam int unsigned CTX_W = $clog2(cfg_pkg::STK_CTX_N);
  localparam int unsigned CNT_W = $clog2(cfg_pkg::STK_PTR_N) + 1;

  typedef logic [CTX_W-1:0] ctx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_PUSH  = 2'd1,
    OP_POP   = 2'd2,
    OP_FLUSH = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_FULL  = 2'd1,
    ERR_EMPTY = 2'd2
  } err_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/stk_pipe_ad_enc.sv
// Lowest-set-bit encoder used as the free-entry allocator.
module stk_pipe_ad_enc
  import std_pkg::*;
#(
  parameter int unsigned N = cfg_pkg::STK_PTR_N
) (
  input  logic [N-1:0] i_map,
  output ptr_t         o_ptr_c,
  output logic         o_any_c
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_ptr_c = '0;
    o_any_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_map[i]) begin
        o_ptr_c = PTR_W'(i);
        o_any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stk_pipe_ad.sv
// Multi-context LIFO over a shared entry pool; issues PUSH/POP pointers to the lookup stage.
module stk_pipe_ad
  import stk_pkg::*;
  import std_pkg::*;
#(
  parameter int unsigned STK_CTX_N = cfg_pkg::STK_CTX_N,
  parameter int unsigned STK_PTR_N = cfg_pkg::STK_PTR_N
) (
  input  logic clk,
  input  logic arst,
  input  logic i_cmd_vld,
  input  op_t  i_cmd_op,
  input  ctx_t i_cmd_ctx,
  output logic o_cmd_rdy,
  output logic o_lk_vld_r,
  output op_t  o_lk_op_r,
  output ctx_t o_lk_ctx_r,
  output ptr_t o_lk_ptr_w,
  output logic o_err_vld_r,
  output err_t o_err_code_r
);

  state_t                     state_q, state_d;
  ctx_t                       flush_ctx_q, flush_ctx_d;
  logic [STK_PTR_N-1:0]       free_q, free_d;
  ptr_t [STK_PTR_N-1:0]       next_q, next_d;
  ptr_t [STK_CTX_N-1:0]       head_q, head_d;
  cnt_t [STK_CTX_N-1:0]       cnt_q, cnt_d;
  logic [STK_CTX_N-1:0]       empty_c;

  logic lk_vld_q, lk_vld_d;
  op_t  lk_op_q, lk_op_d;
  ctx_t lk_ctx_q, lk_ctx_d;
  ptr_t lk_ptr_q, lk_ptr_d;
  logic err_vld_q, err_vld_d;
  err_t err_code_q, err_code_d;

  ptr_t alloc_ptr_c;
  logic alloc_any_c;
  ptr_t sel_ptr_c;

  stk_pipe_ad_enc #(.N(STK_PTR_N)) u_enc (
    .i_map   (free_q),
    .o_ptr_c (alloc_ptr_c),
    .o_any_c (alloc_any_c)
  );

  always_comb begin
    for (int c = 0; c < int'(STK_CTX_N); c++) begin
      empty_c[c] = (cnt_q[c] == '0);
    end
  end

  assign o_cmd_rdy = (state_q == ST_IDLE);

  // Next-state: one command per cycle in IDLE, one entry released per cycle in FLUSH.
  always_comb begin
    state_d     = state_q;
    flush_ctx_d = flush_ctx_q;
    free_d      = free_q;
    next_d      = next_q;
    head_d      = head_q;
    cnt_d       = cnt_q;
    lk_vld_d    = 1'b0;
    lk_op_d     = OP_NOP;
    lk_ctx_d    = '0;
    lk_ptr_d    = '0;
    err_vld_d   = 1'b0;
    err_code_d  = ERR_NONE;
    sel_ptr_c   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_vld) begin
          unique case (i_cmd_op)
            OP_PUSH: begin
              if (alloc_any_c) begin
                free_d[alloc_ptr_c] = 1'b0;
                next_d[alloc_ptr_c] = head_q[i_cmd_ctx];
                head_d[i_cmd_ctx]   = alloc_ptr_c;
                cnt_d[i_cmd_ctx]    = cnt_q[i_cmd_ctx] + CNT_W'(1);
                lk_vld_d            = 1'b1;
                lk_op_d             = OP_PUSH;
                lk_ctx_d            = i_cmd_ctx;
                lk_ptr_d            = alloc_ptr_c;
              end else begin
                err_vld_d  = 1'b1;
                err_code_d = ERR_FULL;
              end
            end
            OP_POP: begin
              if (!empty_c[i_cmd_ctx]) begin
                sel_ptr_c         = head_q[i_cmd_ctx];
                head_d[i_cmd_ctx] = next_q[sel_ptr_c];
                free_d[sel_ptr_c] = 1'b1;
                cnt_d[i_cmd_ctx]  = cnt_q[i_cmd_ctx] - CNT_W'(1);
                lk_vld_d          = 1'b1;
                lk_op_d           = OP_POP;
                lk_ctx_d          = i_cmd_ctx;
                lk_ptr_d          = sel_ptr_c;
              end else begin
                err_vld_d  = 1'b1;
                err_code_d = ERR_EMPTY;
              end
            end
            OP_FLUSH: begin
              if (!empty_c[i_cmd_ctx]) begin
                state_d     = ST_FLUSH;
                flush_ctx_d = i_cmd_ctx;
              end
            end
            default: ;
          endcase
        end
      end
      ST_FLUSH: begin
        sel_ptr_c           = head_q[flush_ctx_q];
        head_d[flush_ctx_q] = next_q[sel_ptr_c];
        free_d[sel_ptr_c]   = 1'b1;
        cnt_d[flush_ctx_q]  = cnt_q[flush_ctx_q] - CNT_W'(1);
        if (cnt_q[flush_ctx_q] == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      flush_ctx_q <= '0;
      free_q      <= '1;
      next_q      <= '0;
      head_q      <= '0;
      cnt_q       <= '0;
      lk_vld_q    <= 1'b0;
      lk_op_q     <= OP_NOP;
      lk_ctx_q    <= '0;
      lk_ptr_q    <= '0;
      err_vld_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      flush_ctx_q <= flush_ctx_d;
      free_q      <= free_d;
      next_q      <= next_d;
      head_q      <= head_d;
      cnt_q       <= cnt_d;
      lk_vld_q    <= lk_vld_d;
      lk_op_q     <= lk_op_d;
      lk_ctx_q    <= lk_ctx_d;
      lk_ptr_q    <= lk_ptr_d;
      err_vld_q   <= err_vld_d;
      err_code_q  <= err_code_d;
    end
  end

  assign o_lk_vld_r   = lk_vld_q;
  assign o_lk_op_r    = lk_op_q;
  assign o_lk_ctx_r   = lk_ctx_q;
  assign o_lk_ptr_w   = lk_ptr_q;
  assign o_err_vld_r  = err_vld_q;
  assign o_err_code_r = err_code_q;

endmodule

// File: tb/tb_stk_pipe_ad.sv
// Scoreboard bench for stk_pipe_ad: directed commands queue expected responses, a negedge monitor checks them.
module tb_stk_pipe_ad;
  import stk_pkg::*;
  import std_pkg::*;

  logic clk = 1'b0;
  logic arst;
  logic i_cmd_vld;
  op_t  i_cmd_op;
  ctx_t i_cmd_ctx;
  logic o_cmd_rdy;
  logic o_lk_vld_r;
  op_t  o_lk_op_r;
  ctx_t o_lk_ctx_r;
  ptr_t o_lk_ptr_w;
  logic o_err_vld_r;
  err_t o_err_code_r;

  typedef struct {
    logic is_err;
    op_t  op;
    ctx_t ctx;
    ptr_t ptr;
    err_t code;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  stk_pipe_ad dut (
    .clk          (clk),
    .arst         (arst),
    .i_cmd_vld    (i_cmd_vld),
    .i_cmd_op     (i_cmd_op),
    .i_cmd_ctx    (i_cmd_ctx),
    .o_cmd_rdy    (o_cmd_rdy),
    .o_lk_vld_r   (o_lk_vld_r),
    .o_lk_op_r    (o_lk_op_r),
    .o_lk_ctx_r   (o_lk_ctx_r),
    .o_lk_ptr_w   (o_lk_ptr_w),
    .o_err_vld_r  (o_err_vld_r),
    .o_err_code_r (o_err_code_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented response must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (!arst && (o_lk_vld_r || o_err_vld_r)) begin
      chk("both_vld", 32'(o_lk_vld_r & o_err_vld_r), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: lk_vld=%0d ptr=%0d err_vld=%0d code=%0d, none expected (t=%0t)",
                 o_lk_vld_r, o_lk_ptr_w, o_err_vld_r, o_err_code_r, $time);
      end else begin
        e = exp_q.pop_front();
        chk("resp_kind_err", 32'(o_err_vld_r), 32'(e.is_err));
        if (e.is_err) begin
          chk("err_code", 32'(o_err_code_r), 32'(e.code));
        end else begin
          chk("lk_op", 32'(o_lk_op_r), 32'(e.op));
          chk("lk_ctx", 32'(o_lk_ctx_r), 32'(e.ctx));
          chk("lk_ptr", 32'(o_lk_ptr_w), 32'(e.ptr));
        end
      end
    end
  end

  task automatic issue(input op_t op, input ctx_t ctx, input logic has_exp, input exp_t e);
    int w = 0;
    while (!o_cmd_rdy && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    if (!o_cmd_rdy) chk("rdy_timeout", 32'(o_cmd_rdy), 32'd1);
    i_cmd_vld = 1'b1;
    i_cmd_op  = op;
    i_cmd_ctx = ctx;
    if (has_exp) exp_q.push_back(e);
    @(posedge clk); #1;
    i_cmd_vld = 1'b0;
    i_cmd_op  = OP_NOP;
    i_cmd_ctx = '0;
  endtask

  task automatic push(input int ctx, input int ptr);
    exp_t e = '{1'b0, OP_PUSH, ctx_t'(ctx), ptr_t'(ptr), ERR_NONE};
    issue(OP_PUSH, ctx_t'(ctx), 1'b1, e);
  endtask

  task automatic pop(input int ctx, input int ptr);
    exp_t e = '{1'b0, OP_POP, ctx_t'(ctx), ptr_t'(ptr), ERR_NONE};
    issue(OP_POP, ctx_t'(ctx), 1'b1, e);
  endtask

  task automatic err(input op_t op, input int ctx, input err_t code);
    exp_t e = '{1'b1, OP_NOP, '0, '0, code};
    issue(op, ctx_t'(ctx), 1'b1, e);
  endtask

  task automatic nop(input op_t op);
    exp_t e = '{1'b0, OP_NOP, '0, '0, ERR_NONE};
    issue(op, '0, 1'b0, e);
  endtask

  // FLUSH, then count the cycles the command port stays busy.
  task automatic flush(input int ctx, input int exp_busy);
    exp_t e = '{1'b0, OP_NOP, '0, '0, ERR_NONE};
    int n = 0;
    issue(OP_FLUSH, ctx_t'(ctx), 1'b0, e);
    while (!o_cmd_rdy && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
    chk("flush_busy_cycles", 32'(n), 32'(exp_busy));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_lk_vld"}, 32'(o_lk_vld_r), 32'd0);
    chk({tag, "_lk_op"}, 32'(o_lk_op_r), 32'(OP_NOP));
    chk({tag, "_lk_ctx"}, 32'(o_lk_ctx_r), 32'd0);
    chk({tag, "_lk_ptr"}, 32'(o_lk_ptr_w), 32'd0);
    chk({tag, "_err_vld"}, 32'(o_err_vld_r), 32'd0);
    chk({tag, "_err_code"}, 32'(o_err_code_r), 32'(ERR_NONE));
    chk({tag, "_rdy"}, 32'(o_cmd_rdy), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    arst      = 1'b1;
    i_cmd_vld = 1'b0;
    i_cmd_op  = OP_NOP;
    i_cmd_ctx = '0;
    idle(3);
    arst = 1'b0;
    idle(1);
    check_reset_outs("reset");

    // Three pushes then LIFO pops on ctx0, then an underflow.
    push(0, 0); push(0, 1); push(0, 2);
    pop(0, 2); pop(0, 1); pop(0, 0);
    err(OP_POP, 0, ERR_EMPTY);
    nop(OP_NOP);
    flush(1, 0);
    idle(2);

    // Fill the pool round-robin, overflow, then reuse of a popped pointer.
    for (int i = 0; i < 16; i++) push(i % 4, i);
    err(OP_PUSH, 1, ERR_FULL);
    pop(2, 14);
    push(1, 14);
    for (int k = 3; k >= 0; k--) pop(0, 4 * k);
    pop(1, 14);
    for (int k = 3; k >= 0; k--) pop(1, 4 * k + 1);
    for (int k = 2; k >= 0; k--) pop(2, 4 * k + 2);
    for (int k = 3; k >= 0; k--) pop(3, 4 * k + 3);
    err(OP_POP, 2, ERR_EMPTY);
    idle(2);

    // Flush of five entries; every pointer must be free again afterwards.
    for (int i = 0; i < 5; i++) push(3, i);
    flush(3, 5);
    err(OP_POP, 3, ERR_EMPTY);
    for (int i = 0; i < 16; i++) push(0, i);
    err(OP_PUSH, 0, ERR_FULL);
    flush(0, 16);
    idle(2);

    // Reset during the second flush step abandons the flush.
    for (int i = 0; i < 4; i++) push(2, i);
    idle(2);
    chk("queue_drained_pre_arst", 32'(exp_q.size()), 32'd0);
    begin
      exp_t e = '{1'b0, OP_NOP, '0, '0, ERR_NONE};
      issue(OP_FLUSH, 2, 1'b0, e);
    end
    chk("flush_rdy_low", 32'(o_cmd_rdy), 32'd0);
    @(posedge clk); #3;
    arst = 1'b1;
    #1;
    check_reset_outs("arst_mid_flush");
    @(posedge clk); #1;
    arst = 1'b0;
    idle(1);
    check_reset_outs("post_arst");
    push(0, 0);
    err(OP_POP, 2, ERR_EMPTY);
    pop(0, 0);
    idle(3);

    chk("queue_drained_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
